// File: rtl/flux_fifo_bank.sv
// flux_fifo_bank: a bank of FLUX independent first-word-fall-through FIFOs.
// Each incoming token is routed to a lane by its tag field, and the lanes
// drain independently of each other.
//
// Parameters:
//   DATA_WIDTH  payload bits per token
//   FLUX        number of lanes (2..16); tag width TW = $clog2(FLUX)
//   DEPTH       entries per lane (power of two, >= 2)
//
// Ports:
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset (clears pointers and counts)
//   din    in   token {tag[TW-1:0], payload[DATA_WIDTH-1:0]}
//   write  in   push din into the lane named by its tag
//   full   out  bit i: lane i holds DEPTH entries
//   dout   out  lane i head token (tag kept) in slice i of width DATA_WIDTH+TW
//   read   in   bit i: pop the head of lane i
//   empty  out  bit i: lane i holds no entries
//   err    out  (only when FLUX_FIFO_ERR_EN is defined) sticky error flags:
//               err[0] = a write was dropped, err[1] = a read hit an empty lane
//
// Optional feature macro: FLUX_FIFO_ERR_EN

module flux_fifo_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2,
    parameter int DEPTH      = 4,
    localparam int TW        = $clog2(FLUX),
    localparam int W         = DATA_WIDTH + TW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      din,
    input  logic              write,
    output logic [FLUX-1:0]   full,
    output logic [W*FLUX-1:0] dout,
    input  logic [FLUX-1:0]   read,
    output logic [FLUX-1:0]   empty
`ifdef FLUX_FIFO_ERR_EN
    ,
    output logic [1:0]        err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [TW-1:0]   tag;
    logic [FLUX-1:0] push;
    logic [FLUX-1:0] pop;

    assign tag = din[W-1:DATA_WIDTH];

    for (genvar i = 0; i < FLUX; i++) begin : g_lane
        logic [W-1:0]  mem [DEPTH];
        logic [PW-1:0] wptr;
        logic [PW-1:0] rptr;
        logic [CW-1:0] cnt;

        // Acceptance is judged on the registered count only, so a pop in the
        // same cycle never makes room for a write to a full lane, and a push
        // in the same cycle never makes a read of an empty lane legal.
        assign push[i]  = write && (int'(tag) == i) && !full[i];
        assign pop[i]   = read[i] && !empty[i];

        assign full[i]  = (cnt == CW'(DEPTH));
        assign empty[i] = (cnt == '0);

        // First-word-fall-through: the head entry is always on the output.
        assign dout[i*W +: W] = mem[rptr];

        // Pointers wrap naturally because DEPTH is a power of two.
        always_ff @(posedge clk) begin
            if (rst) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (push[i]) wptr <= wptr + 1'b1;
                if (pop[i])  rptr <= rptr + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        // Storage is not reset; a stray write during reset is unreachable
        // once the pointers and count have cleared.
        always_ff @(posedge clk) begin
            if (push[i]) mem[wptr] <= din;
        end
    end

`ifdef FLUX_FIFO_ERR_EN
    logic drop;
    logic bad_rd;

    always_comb begin
        // Tags beyond the last lane only exist for non-power-of-two FLUX.
        drop = write && (int'(tag) >= FLUX);
        for (int k = 0; k < FLUX; k++) begin
            if (write && (int'(tag) == k) && full[k]) drop = 1'b1;
        end
        bad_rd = |(read & empty);
    end

    always_ff @(posedge clk) begin
        if (rst) err <= 2'b00;
        else     err <= err | {bad_rd, drop};
    end
`endif

endmodule

// File: tb/tb_flux_fifo_bank.sv
module tb_flux_fifo_bank;

    localparam int DW    = 8;
    localparam int FLUX  = 2;
    localparam int DEPTH = 4;
    localparam int TW    = $clog2(FLUX);
    localparam int W     = DW + TW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [W-1:0]      din = '0;
    logic              write = 1'b0;
    logic [FLUX-1:0]   full;
    logic [W*FLUX-1:0] dout;
    logic [FLUX-1:0]   read = '0;
    logic [FLUX-1:0]   empty;
`ifdef FLUX_FIFO_ERR_EN
    logic [1:0]        err;
`endif

    flux_fifo_bank #(.DATA_WIDTH(DW), .FLUX(FLUX), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .write (write),
        .full  (full),
        .dout  (dout),
        .read  (read),
        .empty (empty)
`ifdef FLUX_FIFO_ERR_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: one queue of tokens per lane plus sticky error flags.
    logic [W-1:0] mq [FLUX][$];
    logic [1:0]   merr = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic w, input logic [W-1:0] d, input logic [FLUX-1:0] r);
        bit pre_full [FLUX];
        bit pre_empty [FLUX];
        int t;
        for (int i = 0; i < FLUX; i++) begin
            pre_full[i]  = (mq[i].size() == DEPTH);
            pre_empty[i] = (mq[i].size() == 0);
        end
        for (int i = 0; i < FLUX; i++) begin
            if (r[i]) begin
                if (!pre_empty[i]) void'(mq[i].pop_front());
                else merr[1] = 1'b1;
            end
        end
        if (w) begin
            t = int'(d[W-1:DW]);
            if (t < FLUX && !pre_full[t]) mq[t].push_back(d);
            else merr[0] = 1'b1;
        end
    endtask

    task automatic check_all(input string where);
        for (int i = 0; i < FLUX; i++) begin
            chk($sformatf("%s empty[%0d]", where, i), 32'(empty[i]), 32'(mq[i].size() == 0));
            chk($sformatf("%s full[%0d]", where, i), 32'(full[i]), 32'(mq[i].size() == DEPTH));
            if (mq[i].size() != 0)
                chk($sformatf("%s dout[%0d]", where, i), 32'(dout[i*W +: W]), 32'(mq[i][0]));
        end
`ifdef FLUX_FIFO_ERR_EN
        chk($sformatf("%s err", where), 32'(err), 32'(merr));
`endif
    endtask

    // One clock: drive inputs, advance model, sample 1 time unit after edge.
    task automatic cycle(input logic w, input logic [W-1:0] d, input logic [FLUX-1:0] r, input string where);
        write = w;
        din   = d;
        read  = r;
        model_step(w, d, r);
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = '0;
        check_all(where);
    endtask

    task automatic do_reset(input logic w, input logic [W-1:0] d);
        rst   = 1'b1;
        write = w;
        din   = d;
        read  = '1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        write = 1'b0;
        read  = '0;
        for (int i = 0; i < FLUX; i++) mq[i].delete();
        merr = 2'b00;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset then idle
        do_reset(1'b0, '0);
        chk("rst empty", 32'(empty), 32'h3);
        chk("rst full", 32'(full), 32'h0);
        cycle(1'b0, '0, 2'b00, "idle");
        chk("idle empty", 32'(empty), 32'h3);

        // One token into each lane, visible the next cycle, then drain both
        cycle(1'b1, 9'h0A5, 2'b00, "w0");
        cycle(1'b1, 9'h13C, 2'b00, "w1");
        chk("two lanes empty", 32'(empty), 32'h0);
        chk("lane0 head", 32'(dout[8:0]), 32'h0A5);
        chk("lane1 head", 32'(dout[17:9]), 32'h13C);
        cycle(1'b0, '0, 2'b11, "rd both");
        chk("drained empty", 32'(empty), 32'h3);

        // Fill lane 0, drop the fifth write, drain in order
        for (int k = 1; k <= 4; k++) cycle(1'b1, W'(k), 2'b00, "fill0");
        chk("lane0 full", 32'(full), 32'h1);
        cycle(1'b1, 9'h005, 2'b00, "overflow");
`ifdef FLUX_FIFO_ERR_EN
        chk("drop err0", 32'(err[0]), 32'h1);
`endif
        chk("overflow head", 32'(dout[8:0]), 32'h001);

        // Full lane: same-cycle write and read pops only
        cycle(1'b1, 9'h077, 2'b01, "full wr+rd");
        chk("full cleared", 32'(full[0]), 32'h0);
        chk("pop head", 32'(dout[8:0]), 32'h002);
        for (int k = 2; k <= 4; k++) begin
            chk("drain order", 32'(dout[8:0]), 32'(k));
            cycle(1'b0, '0, 2'b01, "drain0");
        end
        chk("lane0 drained", 32'(empty), 32'h3);

        // Lane 1 with 2 entries: 8 cycles of push+pop across the wrap
        do_reset(1'b0, '0);
        cycle(1'b1, 9'h110, 2'b00, "l1a");
        cycle(1'b1, 9'h111, 2'b00, "l1b");
        for (int k = 0; k < 8; k++) cycle(1'b1, W'(9'h120 + k), 2'b10, "l1 steady");
        chk("l1 head after wrap", 32'(dout[17:9]), 32'h126);
        cycle(1'b0, '0, 2'b01, "rd empty0");
`ifdef FLUX_FIFO_ERR_EN
        chk("rd empty err1", 32'(err[1]), 32'h1);
`endif
        // Read of an empty lane is ignored even with a same-cycle write
        cycle(1'b1, 9'h033, 2'b01, "wr+rd empty0");
        chk("ignored pop", 32'(dout[8:0]), 32'h033);

        // Reset overrides an in-flight write
        do_reset(1'b0, '0);
        for (int k = 0; k < 3; k++) cycle(1'b1, W'(9'h040 + k), 2'b00, "fill3");
        do_reset(1'b1, 9'h0AA);
        chk("rst wr empty", 32'(empty), 32'h3);
        chk("rst wr full", 32'(full), 32'h0);
        cycle(1'b0, '0, 2'b00, "post rst");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset(1'($urandom_range(0, 1)), W'($urandom));
                check_all("rand rst");
            end else begin
                cycle(1'($urandom_range(0, 3) != 0), W'($urandom),
                      FLUX'($urandom), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flux_fifo_bank.md
FLUX_FIFO_BANK -- requirements
Module: flux_fifo_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bits per token.
REQ-002 SHALL have parameter FLUX, default 2, number of flux lanes (legal range 2..16); TW = $clog2(FLUX) is the tag width.
REQ-003 SHALL have parameter DEPTH, default 4, entries per lane (power of two, >= 2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port din  input  DATA_WIDTH+TW  token: tag in [DATA_WIDTH+TW-1:DATA_WIDTH], payload in [DATA_WIDTH-1:0].
REQ-007 SHALL have port write  input  1  push din into the lane selected by its tag.
REQ-008 SHALL have port full  output  FLUX  bit i high when lane i holds DEPTH entries.
REQ-009 SHALL have port dout  output  (DATA_WIDTH+TW)*FLUX  lane i head token (tag kept) at slice [(i+1)*(DATA_WIDTH+TW)-1 : i*(DATA_WIDTH+TW)].
REQ-010 SHALL have port read  input  FLUX  bit i pops the head of lane i.
REQ-011 SHALL have port empty  output  FLUX  bit i high when lane i holds 0 entries.

Function
REQ-012 Each lane SHALL be an independent circular buffer with DEPTH entries, write pointer, read pointer and a count of width $clog2(DEPTH)+1.
REQ-013 write with tag t < FLUX and full[t]=0 SHALL store din at lane t write pointer and advance it modulo DEPTH.
REQ-014 write with tag t < FLUX and full[t]=1 SHALL be dropped; lane t state is unchanged, even if read[t] is high in the same cycle.
REQ-015 write with tag t >= FLUX (non-power-of-two FLUX only) SHALL be dropped with no lane affected.
REQ-016 read[i] with empty[i]=0 SHALL advance lane i read pointer modulo DEPTH; read[i] with empty[i]=1 SHALL be ignored, including when a write to lane i occurs in that cycle.
REQ-017 Simultaneous accepted push and pop on one lane SHALL leave its count unchanged; pushes and pops on different lanes in one cycle SHALL be independent.
REQ-018 dout SHALL be first-word-fall-through: each lane slice combinationally shows the entry at its read pointer; value is don't-care while empty[i]=1.
REQ-019 A token accepted at edge N SHALL appear on dout and clear empty at edge N (visible in cycle N+1); zero additional latency.
REQ-020 full and empty SHALL be derived from registered counts only (no combinational path from write or read to full/empty).
REQ-021 Tokens SHALL leave each lane in exactly the order accepted into that lane; no ordering across lanes.

Reset
REQ-022 While rst=1 at a clock edge, all pointers and counts SHALL clear; empty SHALL be all ones and full all zeros from the next cycle.
REQ-023 rst SHALL override write and read in the same cycle; tokens in flight at reset are discarded; storage contents need not be cleared.

Configuration
REQ-024 Macro FLUX_FIFO_ERR_EN defined: module SHALL add output err  2 bits; err[0] sticky on any dropped write (REQ-014/015), err[1] sticky on any read to an empty lane; both cleared only by rst.
REQ-025 Macro FLUX_FIFO_ERR_EN undefined: err port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-026 Reset then idle -> empty=2'b11, full=2'b00.
REQ-027 Write 0x0A5 (tag 0, payload 0xA5), then 0x13C (tag 1, payload 0x3C) -> next cycle empty=2'b00, dout lane0=0x0A5, lane1=0x13C; read=2'b11 -> empty=2'b11.
REQ-028 Write tag 0 payloads 0x01..0x04 -> full[0]=1; fifth write 0x05 dropped, err[0]=1 (ERR_EN); reads return 0x01,0x02,0x03,0x04 in order, lane 1 stays empty.
REQ-029 Lane 0 full, same-cycle write 0x077 and read[0] -> pop 0x01 only, count becomes 3, full[0]=0 next cycle.
REQ-030 Lane 1 holds 2 entries, same-cycle write to lane 1 and read[1] for 8 cycles with wrap -> count stays 2, order preserved; read[0] on empty lane 0 -> ignored, err[1]=1 (ERR_EN).
REQ-031 Lane 0 holding 3 tokens, assert rst one cycle with write=1 -> empty=2'b11, full=2'b00, written token absent.
